// File: rtl/masked_aes_pkg.sv
// Shared widths and BRAM timing for the serial masked AES datapath.
package masked_aes_pkg;

  localparam int DATA_W      = 8;
  localparam int RND_W       = 2;
  localparam int ADDR_W      = RND_W + DATA_W;
  localparam int BRAM_RD_LAT = 2;

endpackage

// File: rtl/masked_sbox_valid_pipe.sv
// Valid (and optional refresh-mask) shift pipeline matching the BRAM read latency.
// The mask stages exist only when MASKED_SBOX_REFRESH_EN is defined.
module masked_sbox_valid_pipe
  import masked_aes_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int DEPTH = BRAM_RD_LAT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance_i,
  input  logic         fire_i,
`ifdef MASKED_SBOX_REFRESH_EN
  input  logic [W-1:0] mask_i,
  output logic [W-1:0] mask_o,
`endif
  output logic         valid_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
`ifdef MASKED_SBOX_REFRESH_EN
  logic [W-1:0] mask_q [DEPTH];
  logic [W-1:0] mask_d [DEPTH];
`endif

  // Every stage shifts only on advance so it stays aligned with the stalled BRAM.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign valid_d[gi] = advance_i ? fire_i : valid_q[gi];
`ifdef MASKED_SBOX_REFRESH_EN
      assign mask_d[gi]  = advance_i ? mask_i : mask_q[gi];
`endif
    end else begin : g_tail
      assign valid_d[gi] = advance_i ? valid_q[gi-1] : valid_q[gi];
`ifdef MASKED_SBOX_REFRESH_EN
      assign mask_d[gi]  = advance_i ? mask_q[gi-1] : mask_q[gi];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
`ifdef MASKED_SBOX_REFRESH_EN
      for (int i = 0; i < DEPTH; i++) mask_q[i] <= '0;
`endif
    end else begin
      valid_q <= valid_d;
`ifdef MASKED_SBOX_REFRESH_EN
      for (int i = 0; i < DEPTH; i++) mask_q[i] <= mask_d[i];
`endif
    end
  end

  assign valid_o = valid_q[DEPTH-1];
`ifdef MASKED_SBOX_REFRESH_EN
  assign mask_o  = mask_q[DEPTH-1];
`endif

endmodule

// File: rtl/masked_sbox_bram_ctrl.sv
// Front end for one masked S-box BRAM lookup pair: address forming, latency tracking, backpressure.
// Optional output share refresh is enabled by defining MASKED_SBOX_REFRESH_EN.
module masked_sbox_bram_ctrl #(
  parameter int ADDR_W = masked_aes_pkg::ADDR_W,
  parameter int DATA_W = masked_aes_pkg::DATA_W,
  parameter int RND_W  = masked_aes_pkg::RND_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_s0,
  input  logic [DATA_W-1:0] in_s1,
  input  logic [RND_W-1:0]  in_rnd,
`ifdef MASKED_SBOX_REFRESH_EN
  input  logic [DATA_W-1:0] in_refresh,
`endif
  output logic [ADDR_W-1:0] bram_addra,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic              bram_en,
  output logic              bram_rst,
  input  logic [DATA_W-1:0] bram_doa,
  input  logic [DATA_W-1:0] bram_dob,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_s0,
  output logic [DATA_W-1:0] out_s1,
  output logic [CNT_W-1:0]  op_cnt
);

  logic             advance;
  logic             v2;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

  // A bubble in the output stage always lets the pipe move, even under backpressure.
  assign advance  = ~v2 | out_ready;
  assign in_ready = advance;
  assign bram_en  = advance;
  assign bram_rst = rst;

  // Shares stay separate: each port reads the same page with its own share.
  assign bram_addra = {in_rnd, in_s0};
  assign bram_addrb = {in_rnd, in_s1};

`ifdef MASKED_SBOX_REFRESH_EN
  logic [DATA_W-1:0] m2;

  masked_sbox_valid_pipe #(
    .W     (DATA_W),
    .DEPTH (masked_aes_pkg::BRAM_RD_LAT)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .advance_i (advance),
    .fire_i    (in_valid & advance),
    .mask_i    (in_refresh),
    .mask_o    (m2),
    .valid_o   (v2)
  );

  assign out_s0 = bram_doa ^ m2;
  assign out_s1 = bram_dob ^ m2;
`else
  masked_sbox_valid_pipe #(
    .W     (DATA_W),
    .DEPTH (masked_aes_pkg::BRAM_RD_LAT)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .advance_i (advance),
    .fire_i    (in_valid & advance),
    .valid_o   (v2)
  );

  assign out_s0 = bram_doa;
  assign out_s1 = bram_dob;
`endif

  assign out_valid = v2;

  always_comb begin
    op_cnt_d = op_cnt_q;
    if (out_valid && out_ready) op_cnt_d = op_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) op_cnt_q <= '0;
    else     op_cnt_q <= op_cnt_d;
  end

  assign op_cnt = op_cnt_q;

endmodule

// File: tb/tb_masked_sbox_bram_ctrl.sv
// Bench for masked_sbox_bram_ctrl with a behavioural 2-cycle registered BRAM and a scoreboard.
module tb_masked_sbox_bram_ctrl;

`ifdef MASKED_SBOX_REFRESH_EN
  localparam logic REF_ON = 1'b1;
`else
  localparam logic REF_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_s0, in_s1;
  logic [1:0]  in_rnd;
  logic [7:0]  in_refresh;
  logic [9:0]  bram_addra, bram_addrb;
  logic        bram_en, bram_rst;
  logic [7:0]  bram_doa, bram_dob;
  logic        out_valid, out_ready;
  logic [7:0]  out_s0, out_s1;
  logic [15:0] op_cnt;

  masked_sbox_bram_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_s0      (in_s0),
    .in_s1      (in_s1),
    .in_rnd     (in_rnd),
`ifdef MASKED_SBOX_REFRESH_EN
    .in_refresh (in_refresh),
`endif
    .bram_addra (bram_addra),
    .bram_addrb (bram_addrb),
    .bram_en    (bram_en),
    .bram_rst   (bram_rst),
    .bram_doa   (bram_doa),
    .bram_dob   (bram_dob),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_s0     (out_s0),
    .out_s1     (out_s1),
    .op_cnt     (op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // x26/x49 table slice: the known entries are fixed, the rest is a filler pattern.
  function automatic logic [7:0] tbl(input logic [9:0] a);
    logic [7:0] t;
    case (a)
      10'h008: return 8'hEF;
      10'h009: return 8'hF0;
      10'h208: return 8'h6A;
      default: begin
        t = a[7:0] * 8'd29;
        return t ^ {a[9:8], 6'h15};
      end
    endcase
  endfunction

  // Behavioural BRAM: EN-gated latch followed by EN-gated output register with reset.
  logic [7:0] lat_a, lat_b, reg_a, reg_b;
  always @(posedge clk) begin
    if (bram_en) begin
      lat_a <= tbl(bram_addra);
      lat_b <= tbl(bram_addrb);
    end
    if (bram_rst) begin
      reg_a <= 8'h00;
      reg_b <= 8'h00;
    end else if (bram_en) begin
      reg_a <= lat_a;
      reg_b <= lat_b;
    end
  end
  assign bram_doa = reg_a;
  assign bram_dob = reg_b;

  typedef struct {
    logic [7:0] s0;
    logic [7:0] s1;
    logic [1:0] rnd;
    logic [7:0] refr;
    logic [9:0] addra;
    logic [9:0] addrb;
    logic [7:0] o0;
    logic [7:0] o1;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] sb [$];
  logic [15:0] cur_exp;
  logic [15:0] popped;
  logic        acc, stall_q, stall_seen;
  logic [7:0]  hold_s0, hold_s1;
  int          pass_cnt, total_cnt, n_out, n_out0, exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    in_valid   = 1'b1;
    in_s0      = v.s0;
    in_s1      = v.s1;
    in_rnd     = v.rnd;
    in_refresh = v.refr;
    cur_exp    = {v.o0, v.o1};
  endtask

  // Monitor at the falling edge (handshakes resolve at the next rising edge), then advance.
  task automatic tick();
    @(negedge clk);
    acc = 1'b0;
    if (rst) begin
      sb.delete();
      exp_cnt = 0;
      stall_q = 1'b0;
    end else begin
      if (stall_q && out_valid) begin
        check("hold_s0", 32'(out_s0), 32'(hold_s0));
        check("hold_s1", 32'(out_s1), 32'(hold_s1));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_output: got %0h_%0h expected none", out_s0, out_s1);
        end else begin
          popped = sb.pop_front();
          check("sb_s0", 32'(out_s0), 32'(popped[15:8]));
          check("sb_s1", 32'(out_s1), 32'(popped[7:0]));
          $display("out  s0=%02h s1=%02h", out_s0, out_s1);
        end
        exp_cnt++;
        n_out++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(cur_exp);
        acc = 1'b1;
        $display("in   s0=%02h s1=%02h rnd=%0d", in_s0, in_s1, in_rnd);
      end
      stall_q = out_valid && !out_ready;
      if (stall_q) stall_seen = 1'b1;
      hold_s0 = out_s0;
      hold_s1 = out_s1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; n_out = 0; exp_cnt = 0;
    stall_q = 1'b0; stall_seen = 1'b0; acc = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_s0 = 8'h00; in_s1 = 8'h00; in_rnd = 2'b00; in_refresh = 8'h00; cur_exp = 16'h0;

    vecs[0] = '{8'h08, 8'h09, 2'b00, 8'hFF, 10'h008, 10'h009,
                REF_ON ? 8'h10 : 8'hEF, REF_ON ? 8'h0F : 8'hF0};
    vecs[1] = '{8'h08, 8'h37, 2'b10, 8'h00, 10'h208, 10'h237, 8'h6A, tbl(10'h237)};
    for (int i = 2; i < 8; i++) begin
      vecs[i].s0    = 8'($urandom);
      vecs[i].s1    = 8'($urandom);
      vecs[i].rnd   = 2'($urandom);
      vecs[i].refr  = 8'($urandom);
      vecs[i].addra = {vecs[i].rnd, vecs[i].s0};
      vecs[i].addrb = {vecs[i].rnd, vecs[i].s1};
      vecs[i].o0    = tbl(vecs[i].addra) ^ (REF_ON ? vecs[i].refr : 8'h00);
      vecs[i].o1    = tbl(vecs[i].addrb) ^ (REF_ON ? vecs[i].refr : 8'h00);
    end

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_op_cnt", 32'(op_cnt), 32'd0);
    check("rst_out_s0", 32'(out_s0), 32'd0);
    check("rst_out_s1", 32'(out_s1), 32'd0);
    check("rst_bram_rst", 32'(bram_rst), 32'd0);

    // Single lookup with exact 2-cycle latency
    drive(vecs[0]);
    #1;
    check("single_addra", 32'(bram_addra), 32'h008);
    check("single_addrb", 32'(bram_addrb), 32'h009);
    tick();
    in_valid = 1'b0;
    check("single_t1_valid", 32'(out_valid), 32'd0);
    tick();
    check("single_t2_valid", 32'(out_valid), 32'd1);
    check("single_s0", 32'(out_s0), 32'(vecs[0].o0));
    check("single_s1", 32'(out_s1), 32'(vecs[0].o1));
    check("single_xor", 32'(out_s0 ^ out_s1), 32'(8'hEF ^ 8'hF0));
    tick();
    check("single_op_cnt", 32'(op_cnt), 32'd1);

    // Table-driven stream at full throughput
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("vec%0d_addra", i), 32'(bram_addra), 32'(vecs[i].addra));
      check($sformatf("vec%0d_addrb", i), 32'(bram_addrb), 32'(vecs[i].addrb));
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("stream_drained", sb.size(), 0);
    check("stream_op_cnt", 32'(op_cnt), 32'd9);

    // Backpressure: 4 bytes, consumer stalls from the second output
    n_out0 = n_out;
    begin
      int k;
      k = 0;
      for (int c = 0; c < 30 && (n_out - n_out0) < 4; c++) begin
        out_ready = !(c >= 3 && c < 8);
        if (k < 4) drive(vecs[2 + k]);
        else in_valid = 1'b0;
        #1;
        if (out_valid && !out_ready) begin
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_bram_en", 32'(bram_en), 32'd0);
        end
        tick();
        if (acc) k++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_delivered", n_out - n_out0, 4);
    check("bp_stall_seen", 32'(stall_seen), 32'd1);
    check("bp_sb_empty", sb.size(), 0);
    check("bp_op_cnt", 32'(op_cnt), 32'd13);
    check("bp_op_cnt_model", 32'(op_cnt), 32'(exp_cnt));

    // Mid-flight reset drops both in-flight bytes
    drive(vecs[6]);
    tick();
    drive(vecs[7]);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("mrst_valid%0d", i), 32'(out_valid), 32'd0);
      tick();
    end
    check("mrst_op_cnt", 32'(op_cnt), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
